// File: rtl/layered_pixel_gen.sv
// Two-stage priority compositor: NUM_LAYERS sprite layers over a programmable background.
// Optional frame-counted background flash is built when PIXEL_GEN_FLASH_EN is defined.
`timescale 1ns/1ps
module layered_pixel_gen #(
  parameter int unsigned            NUM_LAYERS   = 4,
  parameter int unsigned            RGB_W        = 12,
  parameter logic [RGB_W-1:0]       BG_RGB       = '0,
  parameter logic [RGB_W-1:0]       FLASH_RGB    = '1,
  parameter int unsigned            FLASH_FRAMES = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        video_on,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic [9:0]                  pixel_x,
  input  logic [9:0]                  pixel_y,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]       layer_on,
  input  logic                        flash_req,
  output logic [RGB_W-1:0]            rgb_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        video_on_out,
  output logic                        frame_tick
);

  logic [NUM_LAYERS*RGB_W-1:0] s1_rgb;
  logic [NUM_LAYERS-1:0]       s1_on;
  logic                        s1_video;
  logic                        s1_hsync;
  logic                        s1_vsync;
  logic                        s1_frame;

  logic [RGB_W-1:0]            win_rgb;
  logic                        win_hit;
  logic [RGB_W-1:0]            bg_rgb;
  logic [RGB_W-1:0]            pix_rgb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_rgb       <= '0;
      s1_on        <= '0;
      s1_video     <= 1'b0;
      s1_hsync     <= 1'b0;
      s1_vsync     <= 1'b0;
      s1_frame     <= 1'b0;
      rgb_out      <= '0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      video_on_out <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      s1_rgb       <= layer_rgb;
      s1_on        <= layer_on;
      s1_video     <= video_on;
      s1_hsync     <= hsync_in;
      s1_vsync     <= vsync_in;
      s1_frame     <= (pixel_x == '0) && (pixel_y == '0) && video_on;
      rgb_out      <= pix_rgb;
      hsync_out    <= s1_hsync;
      vsync_out    <= s1_vsync;
      video_on_out <= s1_video;
      frame_tick   <= s1_frame;
    end
  end

  // Layer 0 is frontmost: first hit in ascending order locks the winner.
  always_comb begin
    win_rgb = '0;
    win_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!win_hit && s1_on[i]) begin
        win_rgb = s1_rgb[i*RGB_W +: RGB_W];
        win_hit = 1'b1;
      end
    end
  end

  always_comb begin
    pix_rgb = '0;
    if (s1_video) begin
      pix_rgb = win_hit ? win_rgb : bg_rgb;
    end
  end

`ifdef PIXEL_GEN_FLASH_EN
  logic [7:0] flash_cnt;
  logic       flash_active;

  // A request outranks the frame decrement so a coincident restart keeps the full count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_cnt <= '0;
    end else if (flash_req) begin
      flash_cnt <= 8'(FLASH_FRAMES);
    end else if (frame_tick && (flash_cnt != '0)) begin
      flash_cnt <= flash_cnt - 8'd1;
    end
  end

  assign flash_active = (flash_cnt != '0);
  assign bg_rgb       = flash_active ? FLASH_RGB : BG_RGB;
`else
  logic                         flash_req_unused;
  localparam logic [RGB_W-1:0]  FLASH_RGB_UNUSED    = FLASH_RGB;
  localparam int unsigned       FLASH_FRAMES_UNUSED = FLASH_FRAMES;

  assign flash_req_unused = flash_req;
  assign bg_rgb           = BG_RGB;
`endif

endmodule

// File: doc/layered_pixel_gen.md
# layered_pixel_gen

Parametrised, pipelined pixel generator combining `NUM_LAYERS` sprite layers (hoop, ball, scoreboard, …) into one RGB stream for the VGA output stage. It replaces the fixed two-object generator with a generic priority compositor and a programmable background. It carries an optional frame-counted background flash for score events. Syncs and `video_on` are delayed through the pipeline so the colour stays aligned with its timing.

## Interface
Parameters:
- `NUM_LAYERS`, 4: number of object layers. Range 1..8.
- `RGB_W`, 12: colour width per pixel.
- `BG_RGB`, 12'h000: background colour when no layer is on.
- `FLASH_RGB`, 12'hFFF: background colour while a flash is active.
- `FLASH_FRAMES`, 8: flash duration in frames. Range 1..255.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: asynchronous, active-high reset.
- `video_on` in 1: visible-area flag from the sync generator.
- `hsync_in` in 1: horizontal sync from the sync generator.
- `vsync_in` in 1: vertical sync from the sync generator.
- `pixel_x` in 10: current pixel column.
- `pixel_y` in 10: current pixel row.
- `layer_rgb` in `NUM_LAYERS*RGB_W`: layer i colour in bits `[i*RGB_W +: RGB_W]`.
- `layer_on` in `NUM_LAYERS`: layer i covers the current pixel.
- `flash_req` in 1: single-cycle pulse that starts or restarts a flash.
- `rgb_out` out `RGB_W`: composited, registered colour.
- `hsync_out` out 1: `hsync_in` delayed 2 cycles.
- `vsync_out` out 1: `vsync_in` delayed 2 cycles.
- `video_on_out` out 1: `video_on` delayed 2 cycles.
- `frame_tick` out 1: one-cycle pulse at the start of each frame.

## Operation
Stage 1 registers every input unchanged: `layer_rgb`, `layer_on`, `video_on`, both syncs, and the frame-start detect `(pixel_x==0 && pixel_y==0 && video_on)`.

Stage 2 composites from the stage-1 registers:
- If stage-1 `video_on` is 0, `rgb_out` = 0. Blanking has the highest priority.
- Otherwise the lowest-index layer with `layer_on` set wins, and its colour is output. Layer 0 is the front layer.
- If no layer is on, output `FLASH_RGB` when `flash_active` is set, else `BG_RGB`.

Frame handling:
- `frame_tick` is the registered stage-1 frame-start detect, so it rises with the first visible pixel of the frame at the output.

Flash counter (only when `PIXEL_GEN_FLASH_EN` is defined):
- Counter `flash_cnt` is 8 bits.
- `flash_active = (flash_cnt != 0)`.
- `flash_req` loads `FLASH_FRAMES`.
- Each `frame_tick` decrements a nonzero count. The count saturates at 0.
- If `flash_req` and `frame_tick` fall in the same cycle, the load wins.
- A `flash_req` during an active flash restarts the full duration.

Reset:
- All pipeline registers clear to 0 and `flash_cnt` clears to 0.
- Reset values: `rgb_out`=0, `hsync_out`=0, `vsync_out`=0, `video_on_out`=0, `frame_tick`=0.
- A reset asserted mid-frame or mid-flash aborts immediately. After release the first valid output appears 2 cycles later.

## Timing
- Latency is fixed at 2 clk from inputs to `rgb_out` and the sync outputs. There are no stalls and no handshake; every cycle is accepted.
- Flash start: a `flash_req` sampled at edge N makes the background `FLASH_RGB` for pixels output from edge N+1 onward.
- Flash length: the flash lasts until `FLASH_FRAMES` `frame_tick` pulses have been seen.
- There is no combinational path from any input to any output.

## Configuration
- `PIXEL_GEN_FLASH_EN` defined: the flash counter and `FLASH_RGB` path are built in as described above.
- `PIXEL_GEN_FLASH_EN` undefined: the counter is removed, `flash_req` is ignored, and the background is always `BG_RGB`. `frame_tick` is still generated.

## Test plan
- Reset then hold `video_on`=0 with layer 0 on and rgb 12'hF00: `rgb_out` stays 0, and `video_on_out` stays 0.
- `video_on`=1, layer 1 on with 12'h0F0 and layer 2 on with 12'h00F: `rgb_out`=12'h0F0 exactly 2 cycles later. Then drop layer 1: output becomes 12'h00F.
- No layers on, `BG_RGB`=12'h123: `rgb_out`=12'h123. Toggle `hsync_in` and `vsync_in`: the outputs match the inputs delayed 2 cycles.
- Flash build with `FLASH_FRAMES`=3, pulse `flash_req`, and run 4 frames with no layers on: background is 12'hFFF for 3 frames, then `BG_RGB`. Repeat with `flash_req` coincident with `frame_tick`: the counter reads 3.
- Assert `reset` mid-flash at pixel (100,50): outputs go to 0 asynchronously, and after release there is no flash.
- Non-flash build: pulse `flash_req`: the background never changes from `BG_RGB`.
